// File: rtl/seq_alu_datapath.sv
// Signed ALU with result register, start/busy/done handshake and an iterative
// shift-add multiplier, plus an independent wrap-around blink timer with two
// threshold flags for the display logic.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; operands and op latched on acceptance
// MUL   | one shift-add iteration per cycle on operand magnitudes
// FIN   | result written to R, done pulsed on the following cycle
module seq_alu_datapath #(
  parameter int WIDTH     = 8,
  parameter int SHORT_CNT = 50000000,
  parameter int LONG_CNT  = 200000000,
  parameter int PERIOD    = 400000000,
  parameter int CW        = $clog2(PERIOD)
) (
  input  logic                      clk,
  input  logic                      clr,
  input  logic [WIDTH-1:0]          A,
  input  logic [WIDTH-1:0]          B,
  input  logic [1:0]                op,
  input  logic                      start,
  input  logic                      reg_clr,
  input  logic                      inc,
  input  logic                      cnt_clr,
  output logic                      busy,
  output logic                      done,
  output logic [2*WIDTH-1:0]        R,
  output logic                      sign,
  output logic                      lt_short,
  output logic                      lt_long,
  output logic [CW-1:0]             count
);

  localparam int IW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(PERIOD - 1);
  localparam logic [CW-1:0] CNT_SHORT = CW'(SHORT_CNT);
  localparam logic [CW-1:0] CNT_LONG  = CW'(LONG_CNT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0]   a_q, b_q;
  logic [1:0]         op_q;
  logic               neg_q;
  logic [2*WIDTH-1:0] acc, mcand;
  logic [WIDTH-1:0]   mplier;
  logic [IW-1:0]      iter;
  logic [2*WIDTH-1:0] ext_a, ext_b, diff, result;

  // Two's-complement magnitude; the most negative value maps to 2^(WIDTH-1),
  // which still fits as an unsigned WIDTH-bit number.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction

  // FSM state register.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic; start is only looked at in IDLE so requests while busy are dropped.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = (op == 2'b10) ? S_MUL : S_FIN;
      S_MUL:  if (iter == '0) state_nxt = S_FIN;
      S_FIN:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);

  // Operand capture and shift-add multiplier; iter counts down the remaining iterations.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      neg_q  <= 1'b0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      iter   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_q    <= A;
            b_q    <= B;
            op_q   <= op;
            neg_q  <= A[WIDTH-1] ^ B[WIDTH-1];
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, mag(A)};
            mplier <= mag(B);
            iter   <= IW'(WIDTH - 1);
          end
        end
        S_MUL: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          if (iter != '0) iter <= iter - IW'(1);
        end
        default: ;
      endcase
    end
  end

  // Operands are sign-extended to the result width, so add/sub/absdiff cannot overflow.
  assign ext_a = {{WIDTH{a_q[WIDTH-1]}}, a_q};
  assign ext_b = {{WIDTH{b_q[WIDTH-1]}}, b_q};
  assign diff  = ext_a - ext_b;

  // Result selection from the latched op.
  always_comb begin
    result = '0;
    case (op_q)
      2'b00: result = ext_a + ext_b;
      2'b01: result = diff;
      2'b10: result = neg_q ? -acc : acc;
      2'b11: result = diff[2*WIDTH-1] ? -diff : diff;
      default: result = '0;
    endcase
  end

  // Result register; reg_clr wins over a completing write but leaves done alone.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      R    <= '0;
      done <= 1'b0;
    end else begin
      done <= (state == S_FIN);
      if (reg_clr)              R <= '0;
      else if (state == S_FIN)  R <= result;
    end
  end

  assign sign = R[2*WIDTH-1];

  // Blink timer: clear beats increment, wraps at PERIOD-1.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr)              count <= '0;
    else if (cnt_clr)      count <= '0;
    else if (inc)          count <= (count == CNT_LAST) ? '0 : count + CW'(1);
  end

  assign lt_short = (count < CNT_SHORT);
  assign lt_long  = (count < CNT_LONG);

endmodule

// File: tb/tb_seq_alu_datapath.sv
// Self-checking bench for seq_alu_datapath: directed vector table, randomized
// operations against an integer-arithmetic model, handshake corner cases and
// a timer walk with a modulo-counter model.
module tb_seq_alu_datapath;

  localparam int W      = 8;
  localparam int SHORT  = 3;
  localparam int LONG   = 6;
  localparam int PER    = 8;
  localparam int MUL_LAT = W + 1;

  logic           clk = 1'b0;
  logic           clr;
  logic [W-1:0]   A, B;
  logic [1:0]     op;
  logic           start, reg_clr, inc, cnt_clr;
  logic           busy, done, sign, lt_short, lt_long;
  logic [2*W-1:0] R;
  logic [2:0]     count;

  int n_cmp = 0;
  int n_bad = 0;

  seq_alu_datapath #(
    .WIDTH(W), .SHORT_CNT(SHORT), .LONG_CNT(LONG), .PERIOD(PER)
  ) dut (
    .clk(clk), .clr(clr), .A(A), .B(B), .op(op), .start(start),
    .reg_clr(reg_clr), .inc(inc), .cnt_clr(cnt_clr), .busy(busy),
    .done(done), .R(R), .sign(sign), .lt_short(lt_short),
    .lt_long(lt_long), .count(count)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]     op;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] exp_r;
    int             lat;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain signed integer arithmetic, truncated to the result width.
  function automatic logic [2*W-1:0] model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb, r;
    logic [63:0] t;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      2'd0: r = sa + sb;
      2'd1: r = sa - sb;
      2'd2: r = sa * sb;
      default: r = (sa > sb) ? sa - sb : sb - sa;
    endcase
    t = r;
    return t[2*W-1:0];
  endfunction

  task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2*W-1:0] er, input int lat, input string nm);
    int n, bc;
    A = a; B = b; op = o; start = 1'b1;
    tick();
    start = 1'b0;
    A = W'($urandom); B = W'($urandom); op = 2'($urandom);
    n = 0; bc = 0;
    while (done !== 1'b1 && n < 40) begin
      if (busy === 1'b1) bc++;
      tick();
      n++;
    end
    check({nm, " latency"}, n, lat);
    check({nm, " busy_cycles"}, bc, lat);
    check({nm, " R"}, R, er);
    check({nm, " sign"}, sign, er[2*W-1]);
    check({nm, " busy_after"}, busy, 0);
    tick();
    check({nm, " done_pulse"}, done, 0);
    check({nm, " R_hold"}, R, er);
  endtask

  initial begin
    int ndone, dedge, mcount;
    logic [1:0] ro;
    logic [W-1:0] ra, rb;
    logic ri, rc;

    vecs[0] = '{2'b00, 8'd127,  8'd1,   16'h0080, 1};
    vecs[1] = '{2'b01, 8'h80,   8'd1,   16'hFF7F, 1};
    vecs[2] = '{2'b11, 8'h80,   8'd127, 16'h00FF, 1};
    vecs[3] = '{2'b10, 8'hF9,   8'd13,  16'hFFA5, MUL_LAT};
    vecs[4] = '{2'b10, 8'h80,   8'h80,  16'h4000, MUL_LAT};
    vecs[5] = '{2'b10, 8'd0,    8'hFB,  16'h0000, MUL_LAT};
    vecs[6] = '{2'b11, 8'd5,    8'd90,  16'h0055, 1};

    clr = 1'b0; A = '0; B = '0; op = '0; start = 1'b0;
    reg_clr = 1'b0; inc = 1'b0; cnt_clr = 1'b0;
    #1;
    check("rst R", R, 0);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst sign", sign, 0);
    check("rst count", count, 0);
    check("rst lt_short", lt_short, 1);
    check("rst lt_long", lt_long, 1);
    tick(); tick();
    clr = 1'b1;
    tick();

    for (int i = 0; i < 7; i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_r, vecs[i].lat, $sformatf("vec%0d", i));

    for (int i = 0; i < 120; i++) begin
      ro = 2'($urandom); ra = W'($urandom); rb = W'($urandom);
      run_op(ro, ra, rb, model(ro, ra, rb), (ro == 2'b10) ? MUL_LAT : 1,
             $sformatf("rnd%0d op%0d %0h %0h", i, ro, ra, rb));
    end

    // Second start during a multiply is dropped.
    A = 8'hF9; B = 8'd13; op = 2'b10; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    A = 8'd1; B = 8'd1; op = 2'b00; start = 1'b1;
    tick();
    start = 1'b0;
    ndone = 0; dedge = 0;
    for (int e = 4; e <= 16; e++) begin
      tick();
      if (done === 1'b1) begin ndone++; dedge = e; end
    end
    check("ignore ndone", ndone, 1);
    check("ignore done_edge", dedge, MUL_LAT);
    check("ignore R", R, 16'hFFA5);

    // Reset in the middle of a multiply aborts it.
    A = 8'd3; B = 8'd5; op = 2'b10; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    clr = 1'b0;
    #1;
    check("abort busy", busy, 0);
    check("abort R", R, 0);
    check("abort done", done, 0);
    tick();
    clr = 1'b1;
    ndone = 0;
    for (int e = 0; e < 14; e++) begin
      tick();
      if (done === 1'b1) ndone++;
    end
    check("abort no_done", ndone, 0);
    check("abort busy_later", busy, 0);

    // reg_clr coincident with the FIN write.
    run_op(2'b00, 8'd5, 8'd6, 16'h000B, 1, "pre_regclr");
    A = 8'd2; B = 8'd3; op = 2'b00; start = 1'b1;
    tick();
    start = 1'b0; reg_clr = 1'b1;
    tick();
    reg_clr = 1'b0;
    check("regclr done", done, 1);
    check("regclr R", R, 0);
    tick();
    check("regclr done_pulse", done, 0);
    check("regclr R_hold", R, 0);

    // Timer walk through two wraps.
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0; inc = 1'b1;
    mcount = 0;
    for (int i = 0; i < 20; i++) begin
      check($sformatf("tmr count i%0d", i), count, mcount);
      check($sformatf("tmr lt_short c%0d", mcount), lt_short, (mcount < SHORT));
      check($sformatf("tmr lt_long c%0d", mcount), lt_long, (mcount < LONG));
      tick();
      mcount = (mcount + 1) % PER;
    end
    while (mcount != 5) begin
      tick();
      mcount = (mcount + 1) % PER;
    end
    check("tmr at5", count, 5);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    mcount = 0;
    check("tmr cnt_clr", count, 0);
    inc = 1'b0;
    tick();
    check("tmr hold", count, 0);

    for (int i = 0; i < 80; i++) begin
      ri = 1'($urandom_range(0, 1));
      rc = ($urandom_range(0, 9) == 0);
      inc = ri; cnt_clr = rc;
      tick();
      if (rc) mcount = 0;
      else if (ri) mcount = (mcount + 1) % PER;
      check($sformatf("tmr rnd%0d count", i), count, mcount);
      check($sformatf("tmr rnd%0d short", i), lt_short, (mcount < SHORT));
      check($sformatf("tmr rnd%0d long", i), lt_long, (mcount < LONG));
    end
    inc = 1'b0; cnt_clr = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seq_alu_datapath.md
Name: seq_alu_datapath

Overview:
Parametrised successor to the team's 8-bit ALU/register/blink-counter datapath.
- Signed ALU of configurable width feeding a result register, with a start/busy/done handshake and an iterative multi-cycle multiplier.
- Parametrised blink timer with a configurable wrap period and two threshold flags.
- Sits between the control FSM (issues start/op) and the seven-segment/LED display logic (consumes R, sign and the timer flags).

Parameters:
- WIDTH, 8, operand width in bits; result is 2*WIDTH bits.
- SHORT_CNT, 50000000, threshold for lt_short.
- LONG_CNT, 200000000, threshold for lt_long; must be < PERIOD.
- PERIOD, 400000000, timer wrap period in clk cycles.
- CW, $clog2(PERIOD), timer counter width (derived).

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  asynchronous, active-low reset for all state.
- A  in  WIDTH  signed operand A.
- B  in  WIDTH  signed operand B.
- op  in  2  operation select: 00 add, 01 sub (A-B), 10 mul, 11 absolute difference |A-B|.
- start  in  1  request; sampled only when busy=0.
- reg_clr  in  1  synchronous clear of R.
- inc  in  1  timer count enable.
- cnt_clr  in  1  synchronous timer clear.
- busy  out  1  high while an operation is in flight.
- done  out  1  one-cycle pulse when R is updated.
- R  out  2*WIDTH  signed result register.
- sign  out  1  equals R[2*WIDTH-1].
- lt_short  out  1  count < SHORT_CNT.
- lt_long  out  1  count < LONG_CNT.
- count  out  CW  timer value.

Behaviour:
- Reset (clr=0, asynchronous): FSM to IDLE; R=0, sign=0, busy=0, done=0; count=0, so lt_short=1 and lt_long=1. Reset mid-multiply aborts it with no done.
- FSM states:
  - IDLE: start=1 latches A, B and op.
    - op != 10: go to FIN.
    - op = 10: go to MUL and set busy=1.
  - MUL: performs WIDTH shift-add iterations on operand magnitudes, one per cycle. The product sign is A_sign XOR B_sign, and the magnitude is negated at the end if that sign is 1. Go to FIN after the last iteration.
  - FIN: writes R, pulses done=1, returns to IDLE. busy=1 in FIN.
- Latency, with start sampled at edge 0:
  - add/sub/absdiff: R and done valid after edge 1.
  - mul: R and done valid after edge WIDTH+1.
- start while busy=1 is ignored, not queued. A, B and op may change freely after the sampling edge.
- Arithmetic:
  - Operands are sign-extended to 2*WIDTH bits before add/sub/absdiff, so no overflow is possible.
  - Mul is an exact signed product, including (-2^(WIDTH-1))^2.
  - absdiff result is always >= 0.
- reg_clr=1 forces R=0 on that edge and has priority over a FIN write in the same cycle; done still pulses. reg_clr does not affect the FSM.
- R holds its value between completions.
- Timer:
  - cnt_clr=1: count goes to 0 (priority over inc).
  - Otherwise, if inc=1: count increments, and wraps from PERIOD-1 to 0.
  - Flags are combinational compares of count.
  - ALU and timer are independent.

Test Plan:
1. WIDTH=8: reset, then op=00, A=127, B=1, start pulse -> busy=1 for one cycle, done at edge 1, R=0x0080, sign=0.
2. op=01, A=-128, B=1 -> R=0xFF7F (-129), sign=1, done after 1 cycle. op=11, A=-128, B=127 -> R=0x00FF (255).
3. op=10, A=-7, B=13 -> busy high for 9 cycles, done at edge 9, R=0xFFA5 (-91). Then A=B=-128 -> R=0x4000. A=0, B=-5 -> R=0x0000, sign=0.
4. Start a mul, pulse start again at edge 3 with op=00 -> second request ignored, single done at edge 9. Assert clr=0 at edge 4 of a new mul -> R=0, busy=0, no done.
5. reg_clr=1 coincident with FIN -> R=0 and done=1.
6. Timer with SHORT_CNT=3, LONG_CNT=6, PERIOD=8, inc=1:
   - lt_short=1 for count 0-2, then 0 from count 3.
   - lt_long=0 from count 6.
   - count goes 7 -> 0 and both flags return to 1.
   - cnt_clr at count 5 -> 0 on the next edge, regardless of inc.
